// File: rtl/ddr3_wr_oserdes_sched_pkg.sv
// Shared types and constants for the DDR3 write-path OSERDES scheduler.
// Holds the lane-sequencing FSM states, the DQS D1..D8 patterns and the helper
// that sizes the write-latency field from the deepest supported latency.
package ddr3_wr_sched_pkg;

    // Lane sequencing phases: DQS preamble, data beat, DQS postamble.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } wr_state_e;

    // D1 is bit 0, so DQS starts high on the first serialized bit of a burst.
    localparam logic [7:0] DQS_TOGGLE = 8'b0101_0101;
    localparam logic [7:0] DQS_IDLE   = 8'h00;

    // Width of a field that can hold any latency from 0 to max_wl inclusive.
    function automatic int wl_width(input int max_wl);
        return $clog2(max_wl + 1);
    endfunction

endpackage

// File: rtl/ddr3_wr_oserdes_sched_if.sv
// Bundle between the controller write stage, the scheduler and the OSERDES
// lanes. The DM path (i_wr_mask / o_dm_d) exists only when DATA_MASK_EN is
// defined. master = controller side, slave = scheduler side.
interface ddr3_wr_oserdes_sched_if
    import ddr3_wr_sched_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int MAX_WL = 8
);

    logic                          i_wr_valid;
    logic                          o_wr_ready;
    logic [LANES*64-1:0]           i_wr_data;
    logic                          i_hold;
    logic [wl_width(MAX_WL)-1:0]   i_wr_lat;
    logic [LANES*64-1:0]           o_dq_d;
    logic [LANES*8-1:0]            o_dq_t;
    logic [LANES*8-1:0]            o_dqs_d;
    logic [LANES-1:0]              o_dqs_t;
    logic                          o_idle;
`ifdef DATA_MASK_EN
    logic [LANES*8-1:0]            i_wr_mask;
    logic [LANES*8-1:0]            o_dm_d;
`endif

`ifdef DATA_MASK_EN
    modport master (
        output i_wr_valid, i_wr_data, i_wr_mask, i_hold, i_wr_lat,
        input  o_wr_ready, o_dq_d, o_dq_t, o_dqs_d, o_dqs_t, o_dm_d, o_idle
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_wr_mask, i_hold, i_wr_lat,
        output o_wr_ready, o_dq_d, o_dq_t, o_dqs_d, o_dqs_t, o_dm_d, o_idle
    );
`else
    modport master (
        output i_wr_valid, i_wr_data, i_hold, i_wr_lat,
        input  o_wr_ready, o_dq_d, o_dq_t, o_dqs_d, o_dqs_t, o_idle
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_hold, i_wr_lat,
        output o_wr_ready, o_dq_d, o_dq_t, o_dqs_d, o_dqs_t, o_idle
    );
`endif

endinterface

// File: rtl/ddr3_wr_delay_line.sv
// Write-latency delay line: a DEPTH-stage shift register of {valid, data}
// advanced every cycle. Stage k holds the entry loaded k+1 edges ago.
// tap_sel picks the output stage; pre_valid reports the stage one earlier so
// the scheduler can open the DQS preamble a cycle ahead. busy covers only the
// stages up to the tap, since anything beyond it has already been consumed.
// RST is a synchronous flush of every valid bit.
module ddr3_wr_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int SEL_W = $clog2(DEPTH)
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] tap_sel,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_data,
    output logic             pre_valid,
    output logic             busy
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Valid bits shift every cycle and are cleared by a flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], in_valid};
        end
    end

    // Payload shifts alongside; it is only consumed where its valid bit is set.
    always_ff @(posedge CLK) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign tap_valid = valid_q[tap_sel];
    assign tap_data  = data_q[tap_sel];
    assign pre_valid = (tap_sel == '0) ? 1'b0 : valid_q[tap_sel - 1'b1];

    // Anything not yet delivered through the tap keeps the line busy.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SEL_W'(i) <= tap_sel) begin
                busy = busy | valid_q[i];
            end
        end
    end

endmodule

// File: rtl/ddr3_wr_oserdes_sched.sv
// DDR3 write-path scheduler for the 8:1 OSERDES lanes, on the CLKDIV clock.
// Accepts one BL8 burst per cycle, delays it by the write latency WL and
// drives D1..D8/T1 of every DQ and DQS lane, with DQS preamble/postamble
// merged across back-to-back and one-gap bursts.
// Optional feature: define DATA_MASK_EN to carry per-lane DM bits with the
// data and drive them on o_dm_d during the data beat.
//
// Because every lane output is registered, the FSM looks one stage ahead of
// the cycle it is producing: tap_valid (stage WL-1) means the next cycle is a
// data beat, pre_valid (stage WL-2) means the cycle after that is.
module ddr3_wr_oserdes_sched
    import ddr3_wr_sched_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int MAX_WL = 8
)(
    input  logic                   CLK,
    input  logic                   RST,
    ddr3_wr_oserdes_sched_if.slave bus
);

    localparam int DQ_W  = LANES * 64;
    localparam int LN_W  = LANES * 8;
    localparam int WL_W  = wl_width(MAX_WL);
    localparam int SEL_W = $clog2(MAX_WL);
`ifdef DATA_MASK_EN
    localparam int ENTRY_W = DQ_W + LN_W;
`else
    localparam int ENTRY_W = DQ_W;
`endif

    logic               accept;
    logic [WL_W-1:0]    wl_eff;
    logic [SEL_W-1:0]   tap_sel;
    logic [ENTRY_W-1:0] line_in;
    logic [ENTRY_W-1:0] tap_data;
    logic               tap_valid;
    logic               pre_valid;
    logic               line_busy;

    wr_state_e state;
    wr_state_e state_nxt;

    logic [DQ_W-1:0]    dq_d_q;
    logic [LN_W-1:0]    dq_t_q;
    logic [LN_W-1:0]    dqs_d_q;
    logic [LANES-1:0]   dqs_t_q;
    logic               idle_q;

    assign bus.o_wr_ready = !RST && !bus.i_hold;
    assign accept         = bus.i_wr_valid && bus.o_wr_ready;

    // Keep the tap inside the line even if an out-of-range latency is applied.
    always_comb begin
        wl_eff = bus.i_wr_lat;
        if (bus.i_wr_lat < WL_W'(2)) begin
            wl_eff = WL_W'(2);
        end else if (bus.i_wr_lat > WL_W'(MAX_WL)) begin
            wl_eff = WL_W'(MAX_WL);
        end
    end

    assign tap_sel = SEL_W'(wl_eff - WL_W'(1));

`ifdef DATA_MASK_EN
    assign line_in = {bus.i_wr_mask, bus.i_wr_data};
`else
    assign line_in = bus.i_wr_data;
`endif

    ddr3_wr_delay_line #(
        .WIDTH (ENTRY_W),
        .DEPTH (MAX_WL)
    ) u_delay_line (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (accept),
        .in_data   (line_in),
        .tap_sel   (tap_sel),
        .tap_valid (tap_valid),
        .tap_data  (tap_data),
        .pre_valid (pre_valid),
        .busy      (line_busy)
    );

    // Lane phase register; a reset drops any burst in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase sequencing. POST doubles as preamble when the next beat is one
    // cycle away, and hands straight to PRE when it is two cycles away.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pre_valid) begin
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                state_nxt = tap_valid ? ST_DATA : ST_POST;
            end
            ST_POST: begin
                if (tap_valid) begin
                    state_nxt = ST_DATA;
                end else if (pre_valid) begin
                    state_nxt = ST_PRE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lane drive registers, decoded from the phase being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dq_d_q  <= '0;
            dq_t_q  <= '1;
            dqs_d_q <= '0;
            dqs_t_q <= '1;
            idle_q  <= 1'b1;
        end else begin
            dq_t_q  <= {LN_W{state_nxt != ST_DATA}};
            dqs_t_q <= {LANES{state_nxt == ST_IDLE}};
            dqs_d_q <= (state_nxt == ST_DATA) ? {LANES{DQS_TOGGLE}} : {LANES{DQS_IDLE}};
            dq_d_q  <= (state_nxt == ST_DATA) ? tap_data[DQ_W-1:0] : '0;
            idle_q  <= (state == ST_IDLE) && !line_busy;
        end
    end

    assign bus.o_dq_d  = dq_d_q;
    assign bus.o_dq_t  = dq_t_q;
    assign bus.o_dqs_d = dqs_d_q;
    assign bus.o_dqs_t = dqs_t_q;
    assign bus.o_idle  = idle_q;

`ifdef DATA_MASK_EN
    logic [LN_W-1:0] dm_d_q;

    // DM follows its data beat and is held low in every other phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dm_d_q <= '0;
        end else begin
            dm_d_q <= (state_nxt == ST_DATA) ? tap_data[ENTRY_W-1:DQ_W] : '0;
        end
    end

    assign bus.o_dm_d = dm_d_q;
`endif

endmodule

// File: tb/tb_ddr3_wr_oserdes_sched.sv
// Directed bench for ddr3_wr_oserdes_sched (LANES=8, MAX_WL=8).
// Define DATA_MASK_EN to also exercise the DM path.
// Each scenario walks a per-cycle table: phase letters I/P/D/Q
// (idle, preamble, data, postamble) and the expected o_idle bit, with cycle k
// being the cycle just after edge k and bursts offered so they are taken at
// edge k. Data beats are expected to carry the pattern offered WL cycles earlier.
module tb_ddr3_wr_oserdes_sched;

    localparam int OW = 1 + 64 + 8 + 64 + 512;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    ddr3_wr_oserdes_sched_if #(.LANES(8), .MAX_WL(8)) bus ();

    ddr3_wr_oserdes_sched #(.LANES(8), .MAX_WL(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [OW-1:0] obs_vec;
    assign obs_vec = {bus.o_idle, bus.o_dq_t, bus.o_dqs_t, bus.o_dqs_d, bus.o_dq_d};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write latency may only move while the scheduler reports idle.
    assert property (@(posedge CLK) disable iff (RST) (!bus.o_idle |-> $stable(bus.i_wr_lat)))
        else $error("[TB] i_wr_lat changed while scheduler busy");

    // Burst payload offered in cycle index k: one byte repeated over all DQ bits.
    function automatic logic [511:0] pat(input int k);
        logic [7:0] b;
        b = 8'hA5 ^ 8'(k * 17);
        return {64{b}};
    endfunction

    // Expected {o_idle, o_dq_t, o_dqs_t, o_dqs_d, o_dq_d} for one phase.
    function automatic logic [OW-1:0] exp_vec(input byte ph, input byte idle_ch, input int src);
        logic [511:0] d;
        logic [63:0]  dqs;
        d   = (ph == "D") ? pat(src) : 512'h0;
        dqs = (ph == "D") ? {8{8'h55}} : 64'h0;
        return {idle_ch == "1", {64{ph != "D"}}, {8{ph == "I"}}, dqs, d};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_latency(input int wl);
        bus.i_wr_lat = 4'(wl);
        tick();
    endtask

    task automatic test_reset();
        RST            = 1'b1;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_hold     = 1'b0;
        bus.i_wr_lat   = 4'd2;
`ifdef DATA_MASK_EN
        bus.i_wr_mask  = '0;
`endif
        #1;
        checks++;
        if (bus.o_wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b exp=0", bus.o_wr_ready);
        end
        tick();
        tick();
        checks++;
        if (obs_vec !== exp_vec("I", "1", 0)) begin
            errors++;
            $display("[TB] FAIL reset_values got=%h exp=%h", obs_vec, exp_vec("I", "1", 0));
        end
`ifdef DATA_MASK_EN
        checks++;
        if (bus.o_dm_d !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_dm got=%h exp=0", bus.o_dm_d);
        end
`endif
        RST = 1'b0;
        #1;
        checks++;
        if (bus.o_wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset got=%b exp=1", bus.o_wr_ready);
        end
        tick();
        checks++;
        if (obs_vec !== exp_vec("I", "1", 0)) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got=%h exp=%h", obs_vec, exp_vec("I", "1", 0));
        end
    endtask

    task automatic test_single_burst();
        string ph = "IIIIPDQII";
        string id = "100000001";
        int    wl = 5;
        set_latency(wl);
        for (int k = 0; k < ph.len(); k++) begin
            bus.i_wr_valid = (k == 0);
            bus.i_wr_data  = pat(k);
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL single cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph[k], id[k], k - wl));
            end
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        string ph = "IPDDDDQII";
        string id = "100000001";
        int    wl = 2;
        set_latency(wl);
        for (int k = 0; k < ph.len(); k++) begin
            bus.i_wr_valid = (k < 4);
            bus.i_wr_data  = pat(k);
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph[k], id[k], k - wl));
            end
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic test_gap();
        string ph1 = "IIPDQDQII";
        string ph2 = "IPDQPDQII";
        string id  = "100000001";
        int    wl  = 3;
        // One idle cycle between bursts: a single POST doubles as preamble.
        set_latency(wl);
        for (int k = 0; k < ph1.len(); k++) begin
            bus.i_wr_valid = (k == 0) || (k == 2);
            bus.i_wr_data  = pat(k);
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph1[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL gap1 cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph1[k], id[k], k - wl));
            end
        end
        // Two idle cycles between bursts: POST hands directly to PRE.
        wl = 2;
        set_latency(wl);
        for (int k = 0; k < ph2.len(); k++) begin
            bus.i_wr_valid = (k == 0) || (k == 3);
            bus.i_wr_data  = pat(k);
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph2[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL gap2 cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph2[k], id[k], k - wl));
            end
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic test_hold();
        string ph = "IIIPDQIPDQII";
        string id = "100000000001";
        int    wl = 4;
        set_latency(wl);
        for (int k = 0; k < ph.len(); k++) begin
            bus.i_wr_valid = (k <= 4);
            bus.i_hold     = (k >= 1) && (k <= 3);
            bus.i_wr_data  = pat(k);
            #1;
            checks++;
            if (bus.o_wr_ready !== !bus.i_hold) begin
                errors++;
                $display("[TB] FAIL hold_ready cyc=%0d got=%b exp=%b", k, bus.o_wr_ready, !bus.i_hold);
            end
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL hold cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph[k], id[k], k - wl));
            end
        end
        bus.i_wr_valid = 1'b0;
        bus.i_hold     = 1'b0;
    endtask

    task automatic test_reset_flush();
        string ph1 = "IIIIIIIIIIIII";
        string id1 = "1001111111111";
        string ph2 = "IIPDIIIII";
        string id2 = "100011111";
        int    wl  = 8;
        // Two bursts deep in a WL=8 line are discarded before any preamble.
        set_latency(wl);
        for (int k = 0; k < ph1.len(); k++) begin
            bus.i_wr_valid = (k < 2);
            bus.i_wr_data  = pat(k);
            RST            = (k == 3);
            #1;
            checks++;
            if (bus.o_wr_ready !== (k != 3)) begin
                errors++;
                $display("[TB] FAIL flush_ready cyc=%0d got=%b exp=%b", k, bus.o_wr_ready, k != 3);
            end
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph1[k], id1[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL flush_wl8 cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph1[k], id1[k], k - wl));
            end
        end
        // Reset landing on the second data beat cuts the lanes back to idle.
        wl = 3;
        set_latency(wl);
        for (int k = 0; k < ph2.len(); k++) begin
            bus.i_wr_valid = (k < 2);
            bus.i_wr_data  = pat(k);
            RST            = (k == 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec(ph2[k], id2[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL flush_wl3 cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph2[k], id2[k], k - wl));
            end
        end
        RST            = 1'b0;
        bus.i_wr_valid = 1'b0;
        tick();
    endtask

`ifdef DATA_MASK_EN
    task automatic test_mask();
        string       ph = "IPDQII";
        string       id = "100001";
        int          wl = 2;
        logic [63:0] dm_exp;
        set_latency(wl);
        for (int k = 0; k < ph.len(); k++) begin
            bus.i_wr_valid = (k == 0);
            bus.i_wr_data  = pat(k);
            bus.i_wr_mask  = (k == 0) ? 64'h0F : 64'hFF;
            tick();
            dm_exp = (ph[k] == "D") ? 64'h0F : 64'h0;
            checks++;
            if (bus.o_dm_d !== dm_exp) begin
                errors++;
                $display("[TB] FAIL mask cyc=%0d got=%h exp=%h", k, bus.o_dm_d, dm_exp);
            end
            checks++;
            if (obs_vec !== exp_vec(ph[k], id[k], k - wl)) begin
                errors++;
                $display("[TB] FAIL mask_lanes cyc=%0d got=%h exp=%h", k, obs_vec, exp_vec(ph[k], id[k], k - wl));
            end
        end
        bus.i_wr_valid = 1'b0;
        bus.i_wr_mask  = '0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] start");
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_gap();
        test_hold();
        test_reset_flush();
`ifdef DATA_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
